// File: rtl/video_pkg.sv
// Shared text-mode video constants, side-band record and the fixed CGA palette.
// The palette is stored as 12-bit RGB (4 bits per channel).
package video_pkg;

    localparam int CELL_W   = 8;
    localparam int CELL_H   = 16;
    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int CELLS    = COLS * ROWS;
    localparam int PIPE_LAT = 5;

    // Per-pixel information that rides alongside the memory fetches.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [2:0] px;
        logic       cursor;
    } sideband_t;

    function automatic logic [11:0] cga_rgb(input logic [3:0] idx);
        logic [11:0] rgb;
        case (idx)
            4'd0:    rgb = 12'h000;
            4'd1:    rgb = 12'h00A;
            4'd2:    rgb = 12'h0A0;
            4'd3:    rgb = 12'h0AA;
            4'd4:    rgb = 12'hA00;
            4'd5:    rgb = 12'hA0A;
            4'd6:    rgb = 12'hA50;
            4'd7:    rgb = 12'hAAA;
            4'd8:    rgb = 12'h555;
            4'd9:    rgb = 12'h55F;
            4'd10:   rgb = 12'h5F5;
            4'd11:   rgb = 12'h5FF;
            4'd12:   rgb = 12'hF55;
            4'd13:   rgb = 12'hF5F;
            4'd14:   rgb = 12'hFF5;
            default: rgb = 12'hFFF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage, W-bit shift register with a synchronous reset value.
// Used for the sync/enable bits and every side-band field that must track the fetch pipeline.
module sync_delay #(
    parameter int            N       = 2,
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [N];
    logic [W-1:0] stage_d [N];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/text_renderer.sv
// 80x30 character-cell renderer: cell fetch, font fetch, palette lookup and cursor,
// producing RGB exactly five clocks after the hc/vc that selected it.
module text_renderer
    import video_pkg::*;
#(
    parameter bit HSYNCPOL     = 1'b0,
    parameter bit VSYNCPOL     = 1'b0,
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    output logic [11:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [11:0] cursor_pos,
    input  logic        cursor_en,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out
);

    localparam sideband_t SB_RST = '{hs: ~HSYNCPOL, vs: ~VSYNCPOL, de: 1'b0, px: 3'd0, cursor: 1'b0};

    logic [6:0]  col;
    logic [4:0]  row;
    logic [3:0]  line;
    logic [11:0] cell_addr;
    logic        unused_coord_bits;

    assign col  = hc[9:3];
    assign row  = vc[8:4];
    assign line = vc[3:0];
    assign unused_coord_bits = ^{hc[10], vc[10:9]};

    // row*80 built from shifts so no multiplier is inferred.
    assign cell_addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};

    logic [11:0] vram_addr_q, vram_addr_d;
    logic [11:0] font_addr_q, font_addr_d;
    logic [3:0]  line_dly;
    logic [7:0]  attr_dly;
    sideband_t   sb_in, sb_dly;

    always_comb begin
        sb_in        = SB_RST;
        sb_in.hs     = hs_in;
        sb_in.vs     = vs_in;
        sb_in.de     = de_in;
        sb_in.px     = hc[2:0];
        sb_in.cursor = cursor_en && (cursor_pos < 12'(CELLS)) &&
                       (cell_addr == cursor_pos) && (line[3:1] == 3'b111);
    end

    always_comb begin
        vram_addr_d = cell_addr;
        font_addr_d = {vram_data[7:0], line_dly};
    end

    // Line arrives with the cell word, two edges after the address is issued.
    sync_delay #(.N(2), .W(4), .RST_VAL(4'd0)) u_line_dly (
        .clk (clk),
        .rst (rst),
        .d   (line),
        .q   (line_dly)
    );

    sync_delay #(.N(2), .W(8), .RST_VAL(8'd0)) u_attr_dly (
        .clk (clk),
        .rst (rst),
        .d   (vram_data[15:8]),
        .q   (attr_dly)
    );

    sync_delay #(.N(PIPE_LAT - 1), .W($bits(sideband_t)), .RST_VAL(SB_RST)) u_sb_dly (
        .clk (clk),
        .rst (rst),
        .d   (sb_in),
        .q   (sb_dly)
    );

    logic       vs_prev_q, vs_prev_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       blink_q, blink_d;
    logic       vs_act;

    assign vs_act = (vs_in == VSYNCPOL);

    always_comb begin
        vs_prev_d   = vs_act;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (vs_act && !vs_prev_q) begin
            if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    logic [11:0] rgb_q, rgb_d;
    logic        hs_out_q, hs_out_d;
    logic        vs_out_q, vs_out_d;
    logic        de_out_q, de_out_d;
    logic [3:0]  fg_idx, bg_idx;
    logic        font_bit;
    logic        use_fg;

    assign fg_idx   = attr_dly[3:0];
    assign bg_idx   = attr_dly[7:4];
    assign font_bit = font_data[3'd7 - sb_dly.px];
    assign use_fg   = font_bit | (sb_dly.cursor & blink_q);

    always_comb begin
        hs_out_d = sb_dly.hs;
        vs_out_d = sb_dly.vs;
        de_out_d = sb_dly.de;
        rgb_d    = 12'h000;
        if (sb_dly.de) begin
            rgb_d = cga_rgb(use_fg ? fg_idx : bg_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vram_addr_q <= 12'd0;
            font_addr_q <= 12'd0;
            vs_prev_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            blink_q     <= 1'b0;
            rgb_q       <= 12'h000;
            hs_out_q    <= ~HSYNCPOL;
            vs_out_q    <= ~VSYNCPOL;
            de_out_q    <= 1'b0;
        end else begin
            vram_addr_q <= vram_addr_d;
            font_addr_q <= font_addr_d;
            vs_prev_q   <= vs_prev_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            rgb_q       <= rgb_d;
            hs_out_q    <= hs_out_d;
            vs_out_q    <= vs_out_d;
            de_out_q    <= de_out_d;
        end
    end

    assign vram_addr = vram_addr_q;
    assign font_addr = font_addr_q;
    assign r         = rgb_q[11:8];
    assign g         = rgb_q[7:4];
    assign b         = rgb_q[3:0];
    assign hs_out    = hs_out_q;
    assign vs_out    = vs_out_q;
    assign de_out    = de_out_q;

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: glyph pixels, address math, sync delay, masking,
// cursor blink and mid-line reset, against hand-computed colours.
module tb_text_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hc, vc;
    logic        hs_in, vs_in, de_in;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] cursor_pos;
    logic        cursor_en;
    logic [3:0]  r, g, b;
    logic        hs_out, vs_out, de_out;

    // clock / reset block
    always #20 clk = ~clk;

    text_renderer #(.HSYNCPOL(1'b0), .VSYNCPOL(1'b0), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .hc         (hc),
        .vc         (vc),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .de_in      (de_in),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .cursor_pos (cursor_pos),
        .cursor_en  (cursor_en),
        .r          (r),
        .g          (g),
        .b          (b),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .de_out     (de_out)
    );

    // Synchronous RAM/ROM models with one clock of read latency.
    logic [15:0] vram_mem [4096];
    logic [7:0]  font_mem [4096];

    always @(posedge clk) begin
        vram_data <= vram_mem[vram_addr];
        font_data <= font_mem[font_addr];
    end

    // scoreboard: each entry is {hs, vs, de, rgb} expected at the outputs
    logic [14:0] exp_q[$];
    localparam logic [14:0] IDLE_EXP = {1'b1, 1'b1, 1'b0, 12'h000};

    int n_checks = 0;
    int n_pass   = 0;
    int step_no  = 0;

    logic [11:0] cell0_exp [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h00A,
                                   12'h00A, 12'hFFF, 12'hFFF, 12'hFFF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // driver: present one pixel for one clock; outputs lag the inputs by four step edges
    task automatic step(input logic [10:0] h, input logic [10:0] v,
                        input logic hs, input logic vs, input logic de,
                        input logic [11:0] rgb);
        logic [14:0] e;
        hc    = h;
        vc    = v;
        hs_in = hs;
        vs_in = vs;
        de_in = de;
        exp_q.push_back({hs, vs, de, rgb});
        @(posedge clk);
        #1;
        step_no++;
        if (exp_q.size() >= 5) begin
            e = exp_q.pop_front();
            check($sformatf("rgb@step%0d", step_no), 32'({r, g, b}), 32'(e[11:0]));
            check($sformatf("sync@step%0d", step_no), 32'({hs_out, vs_out, de_out}), 32'(e[14:12]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(11'd700, 11'd500, 1'b1, 1'b1, 1'b0, 12'h000);
        end
    endtask

    task automatic frame();
        for (int i = 0; i < 3; i++) begin
            step(11'd700, 11'd495, 1'b1, 1'b0, 1'b0, 12'h000);
        end
        idle(3);
    endtask

    task automatic do_reset(input int cycles, input logic [10:0] h, input logic [10:0] v, input logic de);
        rst   = 1'b1;
        hc    = h;
        vc    = v;
        hs_in = 1'b1;
        vs_in = 1'b1;
        de_in = de;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_rgb", 32'({r, g, b}), 32'h0);
            check("rst_sync", 32'({hs_out, vs_out, de_out}), 32'b110);
            check("rst_vram_addr", 32'(vram_addr), 32'h0);
            check("rst_font_addr", 32'(font_addr), 32'h0);
        end
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(IDLE_EXP);
        end
    endtask

    task automatic cursor_pass(input bit shown);
        for (int v = 29; v <= 31; v++) begin
            for (int h = 8; h <= 16; h++) begin
                step(11'(h), 11'(v), 1'b1, 1'b1, 1'b1,
                     (shown && v != 29 && h < 16) ? 12'hA00 : 12'h0A0);
            end
        end
        idle(5);
    endtask

    initial begin
        rst        = 1'b1;
        hc         = 11'd0;
        vc         = 11'd0;
        hs_in      = 1'b1;
        vs_in      = 1'b1;
        de_in      = 1'b0;
        cursor_pos = 12'd81;
        cursor_en  = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            vram_mem[i] = 16'h0000;
            font_mem[i] = 8'h00;
        end
        vram_mem[0]   = 16'hF141;  // 'A', fg 1, bg F
        font_mem[{8'h41, 4'h0}] = 8'h18;
        vram_mem[81]  = 16'h2420;  // blank glyph, fg 4, bg 2
        vram_mem[82]  = 16'h2420;
        vram_mem[116] = 16'h9000;
        vram_mem[117] = 16'h9000;
        vram_mem[118] = 16'h9000;

        do_reset(3, 11'd0, 11'd0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step(11'(i), 11'd0, 1'b1, 1'b1, 1'b1, cell0_exp[i]);
            if (i == 2) check("font_addr_A_row0", 32'(font_addr), 32'h410);
        end

        for (int i = 0; i < 8; i++) begin
            step(11'(i), 11'd0, 1'b1, 1'b1, 1'b0, 12'h000);
        end

        step(11'd639, 11'd479, 1'b1, 1'b1, 1'b1, 12'h000);
        check("vram_addr_last_cell", 32'(vram_addr), 32'd2399);
        step(11'd100, 11'd200, 1'b1, 1'b1, 1'b1, 12'h000);
        check("vram_addr_mid_cell", 32'(vram_addr), 32'd972);
        idle(5);

        for (int h = 650; h <= 760; h++) begin
            step(11'(h), 11'd490, (h >= 656 && h <= 751) ? 1'b0 : 1'b1, 1'b1, 1'b0, 12'h000);
        end
        idle(5);

        cursor_pass(1'b0);
        frame();
        cursor_pass(1'b0);
        frame();
        cursor_pass(1'b1);
        frame();
        cursor_pass(1'b1);
        frame();
        cursor_pass(1'b0);

        // one frame counted, then a reset mid-line must clear counter and pipeline
        frame();
        for (int h = 290; h < 300; h++) begin
            step(11'(h), 11'd16, 1'b1, 1'b1, 1'b1, 12'h55F);
        end
        do_reset(1, 11'd300, 11'd16, 1'b1);
        for (int h = 301; h <= 311; h++) begin
            step(11'(h), 11'd16, 1'b1, 1'b1, 1'b1, 12'h55F);
        end
        idle(5);
        frame();
        cursor_pass(1'b0);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
